// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, receiver alignment states and the
// decoded-word record produced by the word decoder.
package tmds_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } rx_state_e;

  // Index is the control code {c1,c0}; values are q[9:0] as sent on the wire.
  localparam logic [9:0] CTL_TOKEN [0:3] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic [7:0] data;
  } tmds_word_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational 10b -> 8b/2b TMDS word decoder: control tokens map to their
// code, everything else is undone through the inversion and XOR/XNOR stages.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] q,
  output tmds_word_t word
);

  logic [7:0] d;

  // NOTE: every output of a combinational block gets a default on entry so no
  // path through the block can leave a value held, which would infer a latch.
  always_comb begin
    word = '0;
    d    = q[9] ? ~q[7:0] : q[7:0];
    word.data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      word.data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    for (int t = 0; t < 4; t++) begin
      if (q == CTL_TOKEN[t]) begin
        word.is_ctrl = 1'b1;
        word.ctrl    = 2'(t);
      end
    end
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder: deserialises one LSB-first channel, acquires word
// alignment from runs of control tokens and emits decoded words while locked.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERR_W        = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             bit_valid,
  input  logic             serial_bit,
  output logic             word_valid,
  output logic             de,
  output logic [7:0]       data_out,
  output logic [1:0]       ctrl,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_COUNT);

  rx_state_e         state, state_next;
  logic [9:0]        sr, sr_next;
  logic [3:0]        phase;
  logic [RUN_W-1:0]  run, run_step;
  logic [MISS_W-1:0] miss, miss_step;
  tmds_word_t        word;
  logic              tok_hit, at_word_end, lock_now, unlock_now;
  logic              emit, err_inc;

  assign sr_next = {serial_bit, sr[9:1]};

  tmds_word_decode u_decode (
    .q    (sr_next),
    .word (word)
  );

  assign tok_hit     = bit_valid && word.is_ctrl;
  assign at_word_end = bit_valid && (phase == 4'd9);

  // A token extends the run only if the previous boundary, 10 bits back, was a token too.
  assign run_step   = (at_word_end && (run != '0)) ? run + 1'b1 : RUN_W'(1);
  assign miss_step  = miss + 1'b1;
  assign lock_now   = (state == SEARCH) && tok_hit && (run_step == RUN_LOCK);
  assign unlock_now = (state == LOCKED) && tok_hit && !at_word_end && (miss_step == MISS_DROP);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always_ff blocks execute in.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= SEARCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (lock_now)   state_next = LOCKED;
      LOCKED:  if (unlock_now) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    emit    = 1'b0;
    err_inc = 1'b0;
    case (state)
      SEARCH: emit = lock_now;
      LOCKED: begin
        emit    = at_word_end;
        err_inc = tok_hit && !at_word_end;
      end
      default: ;
    endcase
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sr      <= '0;
      phase   <= '0;
      run     <= '0;
      miss    <= '0;
      err_cnt <= '0;
    end else if (bit_valid) begin
      sr    <= sr_next;
      // While searching, any token forces a word boundary right after it.
      phase <= ((state == SEARCH && tok_hit) || phase == 4'd9) ? 4'd0 : phase + 4'd1;

      if (state == SEARCH) begin
        if (tok_hit)          run <= run_step;
        else if (at_word_end) run <= '0;
      end else if (unlock_now) begin
        run  <= '0;
        miss <= '0;
      end else if (at_word_end && tok_hit) begin
        miss <= '0;
      end else if (err_inc) begin
        miss <= miss_step;
      end

      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      word_valid <= 1'b0;
      de         <= 1'b0;
      data_out   <= '0;
      ctrl       <= '0;
    end else begin
      word_valid <= emit;
      if (emit) begin
        de <= !word.is_ctrl;
        if (word.is_ctrl) ctrl     <= word.ctrl;
        else              data_out <= word.data;
      end
    end
  end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Self-checking bench for tmds_rx_decoder: directed scenarios plus random
// token/data/junk/gap streams compared every cycle against a reference model.
module tb_tmds_rx_decoder;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 4;
  localparam int ERR_W    = 4;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             sys_clk    = 1'b0;
  logic             sys_rst    = 1'b1;
  logic             bit_valid  = 1'b0;
  logic             serial_bit = 1'b0;
  logic             word_valid, de, locked;
  logic [7:0]       data_out;
  logic [1:0]       ctrl;
  logic [ERR_W-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  tmds_rx_decoder #(
    .LOCK_COUNT   (LOCK_N),
    .UNLOCK_COUNT (UNLOCK_N),
    .ERR_W        (ERR_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .bit_valid  (bit_valid),
    .serial_bit (serial_bit),
    .word_valid (word_valid),
    .de         (de),
    .data_out   (data_out),
    .ctrl       (ctrl),
    .locked     (locked),
    .err_cnt    (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [7:0] dec_tab [1024];
  bit         hist [$];
  int         n, bnd, last_hit, run, miss, m_err;
  bit         m_locked, m_wv, m_de;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;

  // Forward TMDS encoder stage: XOR/XNOR chain then optional inversion.
  function automatic logic [9:0] encode(logic [7:0] d, bit mode, bit inv);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = mode ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    return {inv, mode, inv ? ~qm : qm};
  endfunction

  function automatic int tok_idx(logic [9:0] q);
    for (int t = 0; t < 4; t++) if (q == tok[t]) return t;
    return -1;
  endfunction

  function automatic logic [9:0] window();
    logic [9:0] q = '0;
    for (int i = 0; i < 10; i++) begin
      int idx = hist.size() - 10 + i;
      if (idx >= 0) q[i] = hist[idx];
    end
    return q;
  endfunction

  function automatic void model_reset();
    hist.delete();
    n = 0; bnd = 0; last_hit = -100; run = 0; miss = 0; m_err = 0;
    m_locked = 0; m_wv = 0; m_de = 0; m_data = '0; m_ctrl = '0;
  endfunction

  function automatic void model_emit(int t, logic [9:0] q);
    m_wv = 1;
    if (t >= 0) begin m_de = 0; m_ctrl = 2'(t); end
    else        begin m_de = 1; m_data = dec_tab[q]; end
  endfunction

  function automatic void model_bit(bit b);
    int k = n;
    logic [9:0] q;
    int t;
    bit done;
    hist.push_back(b);
    n++;
    q    = window();
    t    = tok_idx(q);
    done = ((k - bnd) % 10) == 9;
    m_wv = 0;
    if (!m_locked) begin
      if (t >= 0) begin
        run      = (last_hit == k - 10) ? run + 1 : 1;
        last_hit = k;
        bnd      = k + 1;
        if (run == LOCK_N) begin
          m_locked = 1;
          miss     = 0;
          model_emit(t, q);
        end
      end else if (done) begin
        run = 0;
      end
    end else if (done) begin
      model_emit(t, q);
      if (t >= 0) miss = 0;
    end else if (t >= 0) begin
      if (m_err < ERR_MAX) m_err++;
      miss++;
      if (miss == UNLOCK_N) begin
        m_locked = 0; run = 0; last_hit = -100;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic compare_all();
    check("word_valid", word_valid, m_wv);
    check("de",         de,         m_de);
    check("data_out",   data_out,   m_data);
    check("ctrl",       ctrl,       m_ctrl);
    check("locked",     locked,     m_locked);
    check("err_cnt",    err_cnt,    m_err);
  endtask

  task automatic step(bit valid, bit b);
    bit_valid  = valid;
    serial_bit = b;
    @(posedge sys_clk);
    if (valid) model_bit(b);
    else       m_wv = 0;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    sys_rst    = 1'b1;
    bit_valid  = 1'($urandom_range(0, 1));
    serial_bit = 1'($urandom_range(0, 1));
    @(posedge sys_clk);
    model_reset();
    #1;
    compare_all();
    sys_rst = 1'b0;
  endtask

  // gap: 0 = continuous, 1 = idle cycle after every bit, 2 = random idle cycles
  task automatic send_word(logic [9:0] q, int gap);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, q[i]);
      if (gap == 1 && i != 9) step(1'b0, 1'b0);
      if (gap == 2 && i != 9) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
    end
  endtask

  task automatic send_tok(int t, int count, int gap);
    repeat (count) send_word(tok[t], gap);
  endtask

  function automatic logic [9:0] data_word(logic [7:0] d);
    logic [9:0] q;
    do q = encode(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while (tok_idx(q) >= 0);
    return q;
  endfunction

  initial begin
    for (int d = 0; d < 256; d++)
      for (int m = 0; m < 4; m++)
        dec_tab[encode(8'(d), m[0], m[1])] = 8'(d);

    // 1: reset state, then lock on CTL0
    do_reset();
    check("rst_locked", locked, 1'b0);
    check("rst_err", err_cnt, '0);
    send_tok(0, 4, 0);
    check("t1_lock_wv", word_valid, 1'b1);
    check("t1_locked", locked, 1'b1);
    send_tok(0, 1, 0);
    check("t1_ctrl", ctrl, 2'b00);
    check("t1_de", de, 1'b0);

    // 2: data words, one-cycle latency after the 10th bit
    send_word(data_word(8'h00), 0);
    check("t2_wv0", word_valid, 1'b1);
    check("t2_d00", data_out, 8'h00);
    send_word(data_word(8'hFF), 0);
    check("t2_dFF", data_out, 8'hFF);
    send_word(data_word(8'hA5), 0);
    check("t2_dA5", data_out, 8'hA5);
    check("t2_de", de, 1'b1);
    step(1'b0, 1'b0);
    check("t2_wv_drop", word_valid, 1'b0);

    // 3: junk bits ahead of a CTL3 run
    do_reset();
    repeat (3) step(1'b1, 1'($urandom_range(0, 1)));
    send_tok(3, 6, 0);
    check("t3_locked", locked, 1'b1);
    check("t3_ctrl", ctrl, 2'b11);

    // 4: slip by one bit, unlock, relock; repeat to saturate err_cnt
    do_reset();
    send_tok(1, 4, 0);
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 1'b0);
      send_tok(1, 4, 0);
      if (r == 0) begin
        check("t4_err", err_cnt, 4);
        check("t4_unlocked", locked, 1'b0);
      end
      send_tok(1, 4, 0);
      check("t4_relock", locked, 1'b1);
    end
    check("t4_err_sat", err_cnt, ERR_MAX);

    // 5: strobe every other cycle
    do_reset();
    send_tok(2, 4, 1);
    check("t5_ctrl", ctrl, 2'b10);
    send_word(data_word(8'h3C), 1);
    check("t5_data", data_out, 8'h3C);
    check("t5_de", de, 1'b1);

    // 6: reset in the middle of a word while locked
    send_word(data_word(8'h5A), 0);
    begin
      logic [9:0] q = data_word(8'hC3);
      for (int i = 0; i < 4; i++) step(1'b1, q[i]);
      do_reset();
      check("t6_wv", word_valid, 1'b0);
      check("t6_de", de, 1'b0);
      check("t6_data", data_out, 8'h00);
      check("t6_ctrl", ctrl, 2'b00);
      check("t6_locked", locked, 1'b0);
      for (int i = 4; i < 10; i++) step(1'b1, q[i]);
      check("t6_no_emit", word_valid, 1'b0);
    end

    // random mix
    for (int it = 0; it < 400; it++) begin
      int r   = $urandom_range(0, 99);
      int gap = ($urandom_range(0, 3) == 0) ? 2 : 0;
      if (r < 35)      send_tok($urandom_range(0, 3), $urandom_range(1, 6), gap);
      else if (r < 80) send_word(data_word(8'($urandom)), gap);
      else if (r < 92) repeat ($urandom_range(1, 3)) step(1'b1, 1'($urandom_range(0, 1)));
      else if (r < 98) repeat ($urandom_range(1, 5)) step(1'b0, 1'($urandom_range(0, 1)));
      else             do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
